// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the two-master shared memory port arbiter.
// slave is the arbiter side, master is the CPU/memory environment side.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  inst_req;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_addr_ok;
   logic                  inst_data_ok;
   logic [DATA_WIDTH-1:0] inst_rdata;

   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_WIDTH-1:0] data_addr;
   logic [DATA_WIDTH-1:0] data_wdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;
   logic [DATA_WIDTH-1:0] data_rdata;

   logic                  mem_req;
   logic                  mem_wr;
   logic [1:0]            mem_size;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_addr_ok;
   logic                  mem_data_ok;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size,
      input  data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_req, mem_wr, mem_size,
      output mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata
   );

   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size,
      output data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_req, mem_wr, mem_size,
      input  mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging fetch and load/store onto one memory port.
// One transaction in flight: grant (IDLE), address (ADDR), response (DATA).
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic clock,
   input logic reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  last_q;
   logic                  owner_q;
   logic                  wr_q;
   logic [1:0]            size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  grant_inst;
   logic                  grant_data;
   logic                  live;
   logic                  resp;

   // last_q/owner_q: 1 = data port, 0 = fetch port
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      state_d    = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.inst_req && bus.data_req) begin
               grant_data = !last_q;
               grant_inst = last_q;
            end else begin
               grant_inst = bus.inst_req;
               grant_data = bus.data_req;
            end
            if (grant_inst || grant_data)
               state_d = ADDR;
         end
         ADDR: if (bus.mem_addr_ok) state_d = DATA;
         DATA: if (bus.mem_data_ok) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
         owner_q <= 1'b0;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant_data) begin
            last_q  <= 1'b1;
            owner_q <= 1'b1;
            wr_q    <= bus.data_wr;
            size_q  <= bus.data_size;
            addr_q  <= bus.data_addr;
            wdata_q <= bus.data_wdata;
         end else if (grant_inst) begin
            last_q  <= 1'b0;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd2;
            addr_q  <= bus.inst_addr;
            wdata_q <= '0;
         end
      end
   end

   // Handshake outputs stay quiet while reset is held, whatever the state
   assign live = !reset;
   assign resp = live && (state_q == DATA) && bus.mem_data_ok;

   assign bus.inst_addr_ok = live && grant_inst;
   assign bus.data_addr_ok = live && grant_data;
   assign bus.inst_data_ok = resp && !owner_q;
   assign bus.data_data_ok = resp && owner_q;
   assign bus.inst_rdata   = bus.mem_rdata;
   assign bus.data_rdata   = bus.mem_rdata;

   assign bus.mem_req   = live && (state_q == ADDR);
   assign bus.mem_wr    = wr_q;
   assign bus.mem_size  = size_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of transactions plus
// hand sequences for busy requests, spurious responses and mid-flight reset.
module tb_mem_port_arbiter;

   logic clock;
   logic reset;

   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        inst_req;
      logic        data_req;
      logic [31:0] inst_addr;
      logic [31:0] data_addr;
      logic        data_wr;
      logic [1:0]  data_size;
      logic [31:0] data_wdata;
      int          astall;
      int          dstall;
      logic [31:0] rdata;
      logic        exp_owner;
   } vec_t;

   typedef struct {
      logic        owner;
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[9];
   vec_t v;
   int   n_chk;
   int   n_fail;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_grant(input vec_t t);
      exp_t e;
      @(negedge clock);
      bus.inst_req    = t.inst_req;
      bus.data_req    = t.data_req;
      bus.inst_addr   = t.inst_addr;
      bus.data_addr   = t.data_addr;
      bus.data_wr     = t.data_wr;
      bus.data_size   = t.data_size;
      bus.data_wdata  = t.data_wdata;
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b0;
      #1;
      chk("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(!t.exp_owner));
      chk("data_addr_ok", 32'(bus.data_addr_ok), 32'(t.exp_owner));
      chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
      e.owner = t.exp_owner;
      if (t.exp_owner) begin
         e.addr  = t.data_addr;
         e.wr    = t.data_wr;
         e.size  = t.data_size;
         e.wdata = t.data_wdata;
      end else begin
         e.addr  = t.inst_addr;
         e.wr    = 1'b0;
         e.size  = 2'd2;
         e.wdata = 32'd0;
      end
      sb.push_back(e);
   endtask

   task automatic do_addr(input int stall);
      exp_t e;
      for (int k = 0; k <= stall; k++) begin
         @(negedge clock);
         if (k == 0) begin
            bus.inst_addr  = ~bus.inst_addr;
            bus.data_addr  = ~bus.data_addr;
            bus.data_wdata = ~bus.data_wdata;
            bus.data_wr    = ~bus.data_wr;
            bus.data_size  = ~bus.data_size;
         end
         bus.mem_addr_ok = (k == stall);
         bus.mem_data_ok = 1'b0;
         #1;
         chk("addr_mem_req", 32'(bus.mem_req), 32'd1);
         chk("addr_aok", 32'({bus.inst_addr_ok, bus.data_addr_ok}), 32'd0);
         chk("addr_dok", 32'({bus.inst_data_ok, bus.data_data_ok}), 32'd0);
         if (sb.size() == 0) begin
            chk("sb_empty_addr", 32'd1, 32'd0);
         end else begin
            e = sb[0];
            chk("mem_addr", bus.mem_addr, e.addr);
            chk("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
            chk("mem_size", 32'(bus.mem_size), 32'(e.size));
            chk("mem_wdata", bus.mem_wdata, e.wdata);
         end
      end
   endtask

   task automatic do_data(input int stall, input logic [31:0] rdata);
      exp_t e;
      for (int k = 0; k <= stall; k++) begin
         @(negedge clock);
         bus.mem_addr_ok = 1'b0;
         bus.mem_data_ok = (k == stall);
         bus.mem_rdata   = (k == stall) ? rdata : 32'hDEAD_0000;
         #1;
         chk("data_mem_req", 32'(bus.mem_req), 32'd0);
         chk("data_aok", 32'({bus.inst_addr_ok, bus.data_addr_ok}), 32'd0);
         if (k < stall) begin
            chk("stall_dok", 32'({bus.inst_data_ok, bus.data_data_ok}),
                32'd0);
         end else if (sb.size() == 0) begin
            chk("sb_empty_data", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("inst_data_ok", 32'(bus.inst_data_ok), 32'(!e.owner));
            chk("data_data_ok", 32'(bus.data_data_ok), 32'(e.owner));
            if (e.owner)
               chk("data_rdata", bus.data_rdata, rdata);
            else
               chk("inst_rdata", bus.inst_rdata, rdata);
         end
      end
   endtask

   task automatic run_vec(input vec_t t);
      do_grant(t);
      do_addr(t.astall);
      do_data(t.dstall, t.rdata);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_mem_req"}, 32'(bus.mem_req), 32'd0);
      chk({name, "_aok"}, 32'({bus.inst_addr_ok, bus.data_addr_ok}), 32'd0);
      chk({name, "_dok"}, 32'({bus.inst_data_ok, bus.data_data_ok}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      tbl[0] = '{1, 1, 32'h0000_1000, 32'h0000_2000, 0, 2'd2, 32'h0,
                 0, 0, 32'h1111_0000, 1};
      tbl[1] = '{1, 1, 32'h0000_1004, 32'h0000_2004, 1, 2'd2, 32'h5555_AAAA,
                 0, 0, 32'h2222_0000, 0};
      tbl[2] = '{1, 1, 32'h0000_1008, 32'h0000_2008, 0, 2'd1, 32'h0,
                 1, 0, 32'h3333_0000, 1};
      tbl[3] = '{1, 1, 32'h0000_100C, 32'h0000_200C, 1, 2'd0, 32'h77,
                 0, 1, 32'h4444_0000, 0};
      tbl[4] = '{1, 0, 32'hBFC0_0000, 32'h0, 0, 2'd0, 32'h0,
                 0, 0, 32'h3C1D_0000, 0};
      tbl[5] = '{0, 1, 32'h0, 32'h8000_0003, 1, 2'd0, 32'hAB,
                 2, 0, 32'h0, 1};
      tbl[6] = '{0, 1, 32'h0, 32'h8000_0102, 0, 2'd1, 32'h0,
                 0, 3, 32'hCAFE_BEEF, 1};
      tbl[7] = '{1, 0, 32'h9000_0040, 32'h0, 0, 2'd2, 32'h0,
                 1, 1, 32'h0BAD_F00D, 0};
      tbl[8] = '{1, 1, 32'hA000_0000, 32'hA000_1000, 1, 2'd2, 32'h1234_5678,
                 0, 0, 32'h0, 1};

      reset           = 1'b1;
      bus.inst_req    = 1'b0;
      bus.data_req    = 1'b0;
      bus.inst_addr   = '0;
      bus.data_addr   = '0;
      bus.data_wr     = 1'b0;
      bus.data_size   = 2'd0;
      bus.data_wdata  = '0;
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b0;
      bus.mem_rdata   = '0;

      repeat (2) @(negedge clock);
      bus.inst_req = 1'b1;
      bus.data_req = 1'b1;
      #1;
      chk_quiet("rst");
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("rst_mem_size", 32'(bus.mem_size), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      @(negedge clock);
      reset        = 1'b0;
      bus.inst_req = 1'b0;
      bus.data_req = 1'b0;
      #1;
      chk_quiet("post_rst");

      foreach (tbl[i]) run_vec(tbl[i]);

      // Spurious response while idle
      @(negedge clock);
      bus.inst_req    = 1'b0;
      bus.data_req    = 1'b0;
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata   = 32'hFFFF_FFFF;
      #1;
      chk_quiet("spurious");

      // Load request arriving while a fetch waits for its response
      v = '{1, 0, 32'hBFC0_0010, 32'h0, 0, 2'd0, 32'h0, 0, 0, 32'h0, 0};
      do_grant(v);
      do_addr(0);
      bus.inst_req   = 1'b0;
      bus.data_req   = 1'b1;
      bus.data_addr  = 32'h8000_0200;
      bus.data_wr    = 1'b0;
      bus.data_size  = 2'd2;
      do_data(1, 32'h0102_0304);
      v = '{0, 1, 32'h0, 32'h8000_0200, 0, 2'd2, 32'h0,
            0, 0, 32'h0506_0708, 1};
      run_vec(v);

      // Reset while in DATA abandons the fetch
      v = '{1, 0, 32'hBFC0_0020, 32'h0, 0, 2'd0, 32'h0, 0, 0, 32'h0, 0};
      do_grant(v);
      do_addr(0);
      @(negedge clock);
      reset           = 1'b1;
      bus.inst_req    = 1'b0;
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata   = 32'h5A5A_5A5A;
      #1;
      chk_quiet("in_rst");
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk_quiet("after_rst");
      chk("after_rst_addr", bus.mem_addr, 32'd0);
      sb.delete();

      v = '{1, 0, 32'hBFC0_0030, 32'h0, 0, 2'd0, 32'h0,
            0, 0, 32'h1357_9BDF, 0};
      run_vec(v);
      v = '{1, 1, 32'hBFC0_0034, 32'h8000_0300, 1, 2'd1, 32'hBEEF,
            0, 0, 32'h0, 1};
      run_vec(v);

      @(negedge clock);
      bus.inst_req    = 1'b0;
      bus.data_req    = 1'b0;
      bus.mem_data_ok = 1'b0;
      #1;
      chk_quiet("final");
      chk("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
